// File: rtl/p_input_sel_pipe.sv
// Registered N-way operand selector for the PE P-input path, with a flush-based source switch.
// Latency: 1 clk from src_data/src_valid to out_p/out_valid in RUN; a switch costs FLUSH_CYC+1 edges.
// Backpressure: hold freezes the output register in RUN only; a flush always runs to completion.
module p_input_sel_pipe #(
    parameter int DATA_W    = 32,
    parameter int N_SRC     = 4,
    parameter int FLUSH_CYC = 2,
    localparam int SEL_W    = $clog2(N_SRC)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    input  logic [N_SRC-1:0]        src_valid,
    input  logic [SEL_W-1:0]        sel_req,
    input  logic                    sel_load,
    input  logic                    hold,
    output logic [DATA_W-1:0]       out_p,
    output logic                    out_valid,
    output logic [SEL_W-1:0]        sel_cur,
    output logic                    busy,
    output logic                    sel_err
);

    localparam int CNT_W = $clog2(FLUSH_CYC + 1);
    // Source count widened by one bit so out-of-range indices compare correctly
    // even when N_SRC is a power of two.
    localparam logic [SEL_W:0] N_SRC_EXT = (SEL_W + 1)'(N_SRC);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [SEL_W-1:0]    sel_pend, sel_pend_nxt;
    logic [SEL_W-1:0]    sel_cur_nxt;
    logic [DATA_W-1:0]   out_p_nxt;
    logic                out_valid_nxt;
    logic                busy_nxt;
    logic                sel_err_nxt;

    logic [DATA_W-1:0]   src_arr [N_SRC];
    logic                req_diff;
    logic                req_oob;
    logic                accept;

    // Unpack the flat source bus into one word per source.
    for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
        assign src_arr[i] = src_data[i*DATA_W +: DATA_W];
    end

    assign req_diff = (sel_req != sel_cur);
    assign req_oob  = ({1'b0, sel_req} >= N_SRC_EXT);
    assign accept   = (state == RUN) && sel_load && req_diff && !req_oob;

    // State register plus all registered outputs; reset returns to RUN on source 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            cnt       <= '0;
            sel_pend  <= '0;
            sel_cur   <= '0;
            out_p     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sel_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            sel_pend  <= sel_pend_nxt;
            sel_cur   <= sel_cur_nxt;
            out_p     <= out_p_nxt;
            out_valid <= out_valid_nxt;
            busy      <= busy_nxt;
            sel_err   <= sel_err_nxt;
        end
    end

    // Next-state: accept a switch from RUN, count down the flush, then commit the new source.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        sel_pend_nxt = sel_pend;
        sel_cur_nxt  = sel_cur;
        case (state)
            RUN: begin
                if (accept) begin
                    state_nxt    = FLUSH;
                    cnt_nxt      = CNT_W'(FLUSH_CYC - 1);
                    sel_pend_nxt = sel_req;
                end
            end
            FLUSH: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    state_nxt   = RUN;
                    sel_cur_nxt = sel_pend;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Output next-values: capture or hold in RUN, bubble during a switch, one-shot reject pulse.
    always_comb begin
        out_p_nxt     = out_p;
        out_valid_nxt = out_valid;
        busy_nxt      = (state_nxt == FLUSH);
        sel_err_nxt   = (state == RUN) && sel_load && req_diff && req_oob;
        if (state == FLUSH || accept) begin
            out_valid_nxt = 1'b0;
        end else if (!hold) begin
            out_p_nxt     = src_arr[sel_cur];
            out_valid_nxt = src_valid[sel_cur];
        end
    end

endmodule

// File: tb/tb_p_input_sel_pipe.sv
// Self-checking bench for p_input_sel_pipe: directed steps followed by a randomized run.
// Every edge is compared against an edge-indexed reference model of the switch protocol.
// Uses N_SRC=3 so the 2-bit select can express an out-of-range index.
module tb_p_input_sel_pipe;

    localparam int DATA_W    = 32;
    localparam int N_SRC     = 3;
    localparam int FLUSH_CYC = 2;
    localparam int SEL_W     = $clog2(N_SRC);

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_SRC*DATA_W-1:0] src_data;
    logic [N_SRC-1:0]        src_valid;
    logic [SEL_W-1:0]        sel_req;
    logic                    sel_load;
    logic                    hold;
    logic [DATA_W-1:0]       out_p;
    logic                    out_valid;
    logic [SEL_W-1:0]        sel_cur;
    logic                    busy;
    logic                    sel_err;

    int errors = 0;
    int checks = 0;

    // Reference model: a switch accepted at edge number e finishes at edge e+FLUSH_CYC.
    logic [DATA_W-1:0] m_out_p;
    logic              m_out_valid;
    int                m_sel_cur;
    logic              m_busy;
    logic              m_sel_err;
    bit                m_switching;
    int                m_done_edge;
    int                m_pend;
    int                edge_no = 0;

    p_input_sel_pipe #(
        .DATA_W   (DATA_W),
        .N_SRC    (N_SRC),
        .FLUSH_CYC(FLUSH_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .src_data (src_data),
        .src_valid(src_valid),
        .sel_req  (sel_req),
        .sel_load (sel_load),
        .hold     (hold),
        .out_p    (out_p),
        .out_valid(out_valid),
        .sel_cur  (sel_cur),
        .busy     (busy),
        .sel_err  (sel_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int req;
        req = int'(sel_req);
        edge_no++;
        m_sel_err = 1'b0;
        if (rst) begin
            m_out_p     = '0;
            m_out_valid = 1'b0;
            m_sel_cur   = 0;
            m_busy      = 1'b0;
            m_switching = 1'b0;
        end else if (m_switching) begin
            m_out_valid = 1'b0;
            if (edge_no == m_done_edge) begin
                m_sel_cur   = m_pend;
                m_busy      = 1'b0;
                m_switching = 1'b0;
            end else begin
                m_busy = 1'b1;
            end
        end else if (sel_load && req != m_sel_cur && req < N_SRC) begin
            m_pend      = req;
            m_done_edge = edge_no + FLUSH_CYC;
            m_switching = 1'b1;
            m_busy      = 1'b1;
            m_out_valid = 1'b0;
        end else begin
            if (sel_load && req >= N_SRC) m_sel_err = 1'b1;
            if (!hold) begin
                m_out_p     = src_data[m_sel_cur*DATA_W +: DATA_W];
                m_out_valid = src_valid[m_sel_cur];
            end
        end
    endtask

    // One clock edge: update the model from the inputs present at the edge, then compare.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("out_p",     out_p,               m_out_p);
        check("out_valid", 32'(out_valid),      32'(m_out_valid));
        check("sel_cur",   32'(sel_cur),        32'(m_sel_cur));
        check("busy",      32'(busy),           32'(m_busy));
        check("sel_err",   32'(sel_err),        32'(m_sel_err));
    endtask

    initial begin
        rst = 1'b1; src_data = '0; src_valid = '0; sel_req = '0; sel_load = 1'b0; hold = 1'b0;
        m_out_p = '0; m_out_valid = 1'b0; m_sel_cur = 0; m_busy = 1'b0; m_sel_err = 1'b0;
        m_switching = 1'b0; m_done_edge = 0; m_pend = 0;

        // Reset for two edges
        step(); step();
        check("rst_out_p", out_p, 32'h0);
        check("rst_busy",  32'(busy), 32'h0);

        // Source 0 captured one edge after being applied
        rst = 1'b0;
        src_data = {32'hC3C3_C3C3, 32'h5555_5555, 32'hAAAA_AAAA};
        src_valid = 3'b111;
        step();
        check("cap_src0", out_p, 32'hAAAA_AAAA);
        check("cap_src0_v", 32'(out_valid), 32'h1);

        // Switch to source 1: two bubble edges, commit, then capture
        sel_load = 1'b1; sel_req = 2'd1;
        step();                                   // E
        check("sw_busy_E", 32'(busy), 32'h1);
        check("sw_v_E", 32'(out_valid), 32'h0);
        sel_load = 1'b0;
        step();                                   // E+1
        check("sw_busy_E1", 32'(busy), 32'h1);
        step();                                   // E+2
        check("sw_busy_E2", 32'(busy), 32'h0);
        check("sw_sel_E2", 32'(sel_cur), 32'h1);
        check("sw_v_E2", 32'(out_valid), 32'h0);
        step();                                   // E+3
        check("sw_cap_E3", out_p, 32'h5555_5555);
        check("sw_v_E3", 32'(out_valid), 32'h1);

        // Back to source 0; a request made during the flush is ignored
        sel_load = 1'b1; sel_req = 2'd0;
        step();
        sel_req = 2'd2;
        step();
        check("flush_no_err", 32'(sel_err), 32'h0);
        sel_load = 1'b0;
        step();
        check("flush_ignored", 32'(sel_cur), 32'h0);
        step();
        check("back_src0", out_p, 32'hAAAA_AAAA);

        // Hold freezes the output while source 0 changes
        hold = 1'b1;
        src_data[31:0] = 32'h1234_5678;
        step(); step();
        check("hold_keep", out_p, 32'hAAAA_AAAA);
        hold = 1'b0;
        step();
        check("hold_release", out_p, 32'h1234_5678);

        // Out-of-range request: one-cycle error pulse, no switch
        sel_load = 1'b1; sel_req = 2'd3;
        step();
        check("oob_err", 32'(sel_err), 32'h1);
        check("oob_busy", 32'(busy), 32'h0);
        sel_load = 1'b0;
        step();
        check("oob_err_clr", 32'(sel_err), 32'h0);
        check("oob_sel", 32'(sel_cur), 32'h0);

        // Request for the current source: no bubble
        sel_load = 1'b1; sel_req = 2'd0;
        step();
        check("same_no_bubble", 32'(out_valid), 32'h1);
        sel_load = 1'b0;

        // Reset right after an accepted switch aborts it
        sel_load = 1'b1; sel_req = 2'd2;
        step();
        sel_load = 1'b0; rst = 1'b1;
        step();
        check("abort_sel", 32'(sel_cur), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        step(); step(); step();
        check("abort_stays", 32'(sel_cur), 32'h0);

        // Invalid source 0 still passes its data through
        src_valid[0] = 1'b0;
        src_data[31:0] = 32'hDEAD_BEEF;
        step();
        check("inv_v", 32'(out_valid), 32'h0);
        check("inv_data", out_p, 32'hDEAD_BEEF);

        // Randomized run against the model
        for (int n = 0; n < 600; n++) begin
            src_data  = {$urandom, $urandom, $urandom};
            src_valid = 3'($urandom);
            sel_req   = 2'($urandom_range(0, 3));
            sel_load  = ($urandom_range(0, 3) == 0);
            hold      = ($urandom_range(0, 4) == 0);
            rst       = ($urandom_range(0, 60) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
